// File: rtl/mat_mult_arbiter_if.sv
// mat_mult_arbiter_if: requester handshake and mat_mult4D engine control bundle.
// The arbiter connects through the slave modport; the requester/engine side uses master.
interface mat_mult_arbiter_if;
    localparam int unsigned N_REQ = 3;
    localparam int unsigned SEL_W = 2;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] grant;
    logic [SEL_W-1:0] sel;
    logic             mm_start;
    logic             mm_done;
    logic [N_REQ-1:0] ack;
    logic             busy;
    logic             timeout_err;

    modport master (
        output req,
        output mm_done,
        input  grant,
        input  sel,
        input  mm_start,
        input  ack,
        input  busy,
        input  timeout_err
    );

    modport slave (
        input  req,
        input  mm_done,
        output grant,
        output sel,
        output mm_start,
        output ack,
        output busy,
        output timeout_err
    );
endinterface

// File: rtl/mat_mult_arbiter.sv
// mat_mult_arbiter: round-robin owner of one shared mat_mult4D engine for three requesters.
// Define MAT_ARB_TIMEOUT_EN to abort engine waits after TIMEOUT_CYCLES and raise timeout_err.
module mat_mult_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clock,
    input  logic              resetn,
    mat_mult_arbiter_if.slave bus
);
    localparam int unsigned N_REQ = 3;
    localparam int unsigned SEL_W = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_START,
        S_WAIT_LOW,
        S_WAIT_HIGH,
        S_ACK
    } state_e;

    state_e           state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] last_q, last_d;
    logic             mm_start_q, mm_start_d;
    logic             busy_q, busy_d;

    logic [SEL_W-1:0] cand1_c, cand2_c, winner_c;
    logic             win_valid_c;
    logic             tmo_c;

    // Next index in round-robin order, wrapping 2 -> 0.
    function automatic logic [SEL_W-1:0] rr_next(input logic [SEL_W-1:0] idx);
        return (idx >= SEL_W'(N_REQ - 1)) ? '0 : idx + SEL_W'(1);
    endfunction

`ifdef MAT_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_err_q, timeout_err_d;

    assign tmo_c = (cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_c = 1'b0;
`endif

    // Round-robin pick: search starts just after the last served requester.
    always_comb begin
        cand1_c     = rr_next(last_q);
        cand2_c     = rr_next(cand1_c);
        winner_c    = last_q;
        win_valid_c = |bus.req;
        if (bus.req[cand1_c]) begin
            winner_c = cand1_c;
        end else if (bus.req[cand2_c]) begin
            winner_c = cand2_c;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        sel_d      = sel_q;
        last_d     = last_q;
        mm_start_d = 1'b0;
        ack_d      = '0;
        busy_d     = 1'b0;
`ifdef MAT_ARB_TIMEOUT_EN
        cnt_d         = cnt_q;
        timeout_err_d = timeout_err_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (win_valid_c) begin
                    state_d = S_GRANT;
                    sel_d   = winner_c;
                    grant_d = N_REQ'(1) << winner_c;
                end
            end
            S_GRANT: begin
                state_d = S_START;
            end
            S_START: begin
                state_d = S_WAIT_LOW;
`ifdef MAT_ARB_TIMEOUT_EN
                cnt_d = '0;
`endif
            end
            S_WAIT_LOW: begin
`ifdef MAT_ARB_TIMEOUT_EN
                cnt_d = cnt_q + CNT_W'(1);
`endif
                if (!bus.mm_done) begin
                    state_d = S_WAIT_HIGH;
                end else if (tmo_c) begin
                    state_d = S_ACK;
`ifdef MAT_ARB_TIMEOUT_EN
                    timeout_err_d = 1'b1;
`endif
                end
            end
            S_WAIT_HIGH: begin
`ifdef MAT_ARB_TIMEOUT_EN
                cnt_d = cnt_q + CNT_W'(1);
`endif
                if (bus.mm_done) begin
                    state_d = S_ACK;
                end else if (tmo_c) begin
                    state_d = S_ACK;
`ifdef MAT_ARB_TIMEOUT_EN
                    timeout_err_d = 1'b1;
`endif
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
                last_d  = sel_q;
                grant_d = '0;
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase

        // Registered outputs are decoded from the state being entered.
        mm_start_d = (state_d == S_START);
        ack_d      = (state_d == S_ACK) ? grant_d : '0;
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            sel_q      <= '0;
            last_q     <= SEL_W'(N_REQ - 1);
            mm_start_q <= 1'b0;
            ack_q      <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            sel_q      <= sel_d;
            last_q     <= last_d;
            mm_start_q <= mm_start_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
        end
    end

`ifdef MAT_ARB_TIMEOUT_EN
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.timeout_err = timeout_err_q;
`else
    assign bus.timeout_err = 1'b0;
`endif

    assign bus.grant    = grant_q;
    assign bus.sel      = sel_q;
    assign bus.mm_start = mm_start_q;
    assign bus.ack      = ack_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_mat_mult_arbiter.sv
// tb_mat_mult_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
// Build with MAT_ARB_TIMEOUT_EN defined to exercise the engine-timeout path.
module tb_mat_mult_arbiter;
`ifdef MAT_ARB_TIMEOUT_EN
    localparam int unsigned TO_CYC     = 8;
    localparam int          SINGLE_RUN = 5;
`else
    localparam int unsigned TO_CYC     = 255;
    localparam int          SINGLE_RUN = 40;
`endif

    logic clock;
    logic resetn;
    int   n_checks;
    int   n_pass;
    int   eng_run;
    bit   eng_stuck;

    mat_mult_arbiter_if bus ();

    mat_mult_arbiter #(.TIMEOUT_CYCLES(TO_CYC)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Engine model: done is high when idle, drops the cycle after a start pulse, rises eng_run cycles later.
    initial begin : engine
        int st;
        int cnt;
        st = 0;
        cnt = 0;
        bus.mm_done = 1'b1;
        forever begin
            @(negedge clock);
            if (!resetn) begin
                st = 0;
                bus.mm_done = 1'b1;
            end else if (st == 0) begin
                if (bus.mm_start && !eng_stuck) st = 1;
            end else if (st == 1) begin
                bus.mm_done = 1'b0;
                cnt = eng_run;
                st = 2;
            end else begin
                if (cnt <= 1) begin
                    bus.mm_done = 1'b1;
                    st = 0;
                end else begin
                    cnt = cnt - 1;
                end
            end
        end
    end

    // Spec-level round robin: first requesting index after last, wrapping 2 -> 0.
    function automatic int rr_pick(input logic [2:0] r, input int last);
        int unsigned rv;
        rv = 32'(r);
        for (int k = 1; k <= 3; k++) begin
            int i;
            i = (last + k) % 3;
            if (((rv >> i) & 1) != 0) return i;
        end
        return -1;
    endfunction

    task automatic do_reset();
        resetn = 1'b0;
        bus.req = 3'b000;
        eng_stuck = 1'b0;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        bus.req = 3'b000;
        #1;
        n_checks++;
        if ({bus.grant, bus.sel, bus.mm_start, bus.ack, bus.busy, bus.timeout_err} !== 11'd0)
            $display("FAIL reset_outputs got grant=%b sel=%0d start=%b ack=%b busy=%b terr=%b exp all 0",
                     bus.grant, bus.sel, bus.mm_start, bus.ack, bus.busy, bus.timeout_err);
        else n_pass++;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clock); #1;
            n_checks++;
            if (bus.grant !== 3'b000 || bus.busy !== 1'b0)
                $display("FAIL idle_no_req cyc=%0d got grant=%b busy=%b exp 000/0", c, bus.grant, bus.busy);
            else n_pass++;
        end
    endtask

    task automatic test_single();
        bit seen_low;
        bit got_ack;
        int starts;
        do_reset();
        eng_run = SINGLE_RUN;
        bus.req = 3'b010;
        @(posedge clock); #1;
        n_checks++;
        if (bus.grant !== 3'b010 || bus.sel !== 2'd1 || bus.busy !== 1'b1 || bus.mm_start !== 1'b0)
            $display("FAIL single_grant got grant=%b sel=%0d busy=%b start=%b exp 010/1/1/0",
                     bus.grant, bus.sel, bus.busy, bus.mm_start);
        else n_pass++;
        seen_low = 1'b0;
        got_ack = 1'b0;
        starts = 0;
        for (int c = 0; c < 200 && !got_ack; c++) begin
            @(posedge clock); #1;
            if (bus.mm_start) starts++;
            if (c == 0) begin
                n_checks++;
                if (bus.mm_start !== 1'b1)
                    $display("FAIL single_start_timing got mm_start=%b exp 1", bus.mm_start);
                else n_pass++;
            end
            if (c >= 2 && seen_low && bus.mm_done) begin
                got_ack = 1'b1;
                n_checks++;
                if (bus.ack !== 3'b010 || bus.grant !== 3'b010 || bus.sel !== 2'd1)
                    $display("FAIL single_ack got ack=%b grant=%b sel=%0d exp 010/010/1",
                             bus.ack, bus.grant, bus.sel);
                else n_pass++;
            end else begin
                if (c >= 2 && !bus.mm_done) seen_low = 1'b1;
                n_checks++;
                if (bus.ack !== 3'b000 || bus.grant !== 3'b010)
                    $display("FAIL single_hold cyc=%0d got ack=%b grant=%b exp 000/010", c, bus.ack, bus.grant);
                else n_pass++;
            end
        end
        n_checks++;
        if (!got_ack || starts != 1)
            $display("FAIL single_complete got ack_seen=%0d starts=%0d exp 1/1", got_ack, starts);
        else n_pass++;
        @(negedge clock);
        bus.req = 3'b000;
        for (int c = 0; c < 2; c++) begin
            @(posedge clock); #1;
            n_checks++;
            if (bus.grant !== 3'b000 || bus.busy !== 1'b0 || bus.ack !== 3'b000)
                $display("FAIL single_release cyc=%0d got grant=%b busy=%b ack=%b exp 000/0/000",
                         c, bus.grant, bus.busy, bus.ack);
            else n_pass++;
        end
    endtask

    task automatic test_all_req();
        int order[4];
        int exp_order[4];
        int n_ack;
        exp_order = '{0, 1, 2, 0};
        do_reset();
        eng_run = int'($urandom_range(1, 4));
        bus.req = 3'b111;
        n_ack = 0;
        for (int c = 0; c < 300 && n_ack < 4; c++) begin
            @(posedge clock); #1;
            n_checks++;
            if (!$onehot0(bus.grant) || (bus.ack !== 3'b000 && bus.ack !== bus.grant) ||
                (bus.ack !== 3'b000 && bus.mm_start))
                $display("FAIL all_req_onehot cyc=%0d got grant=%b ack=%b start=%b",
                         c, bus.grant, bus.ack, bus.mm_start);
            else n_pass++;
            for (int i = 0; i < 3; i++)
                if (bus.ack == 3'(1 << i)) begin
                    order[n_ack] = i;
                    n_ack++;
                end
        end
        n_checks++;
        if (n_ack != 4) $display("FAIL all_req_count got %0d acks exp 4", n_ack);
        else n_pass++;
        for (int k = 0; k < 4 && k < n_ack; k++) begin
            n_checks++;
            if (order[k] != exp_order[k])
                $display("FAIL all_req_order idx=%0d got %0d exp %0d", k, order[k], exp_order[k]);
            else n_pass++;
        end
        @(negedge clock);
        bus.req = 3'b000;
    endtask

    task automatic test_drop_req();
        bit in_high;
        bit got_ack;
        do_reset();
        eng_run = 6;
        bus.req = 3'b001;
        in_high = 1'b0;
        for (int c = 0; c < 50 && !in_high; c++) begin
            @(posedge clock); #1;
            if (bus.grant == 3'b001 && !bus.mm_done) in_high = 1'b1;
        end
        @(negedge clock);
        bus.req = 3'b000;
        got_ack = 1'b0;
        for (int c = 0; c < 50 && !got_ack; c++) begin
            @(posedge clock); #1;
            n_checks++;
            if (bus.grant !== 3'b001)
                $display("FAIL drop_grant_held cyc=%0d got grant=%b exp 001", c, bus.grant);
            else n_pass++;
            if (bus.ack !== 3'b000) begin
                got_ack = 1'b1;
                n_checks++;
                if (bus.ack !== 3'b001) $display("FAIL drop_ack got ack=%b exp 001", bus.ack);
                else n_pass++;
            end
        end
        n_checks++;
        if (!in_high || !got_ack) $display("FAIL drop_complete got wait_high=%0d ack=%0d exp 1/1", in_high, got_ack);
        else n_pass++;
        for (int c = 0; c < 4; c++) begin
            @(posedge clock); #1;
            n_checks++;
            if (bus.grant !== 3'b000 || bus.ack !== 3'b000)
                $display("FAIL drop_no_regrant cyc=%0d got grant=%b ack=%b exp 000/000", c, bus.grant, bus.ack);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        bit in_high;
        int bad;
        do_reset();
        eng_run = 30;
        bus.req = 3'b100;
        in_high = 1'b0;
        for (int c = 0; c < 50 && !in_high; c++) begin
            @(posedge clock); #1;
            if (bus.grant == 3'b100 && !bus.mm_done) in_high = 1'b1;
        end
        #1;
        resetn = 1'b0;
        #1;
        n_checks++;
        if (!in_high || bus.grant !== 3'b000 || bus.busy !== 1'b0 || bus.mm_start !== 1'b0 || bus.ack !== 3'b000)
            $display("FAIL reset_mid_async got wait_high=%0d grant=%b busy=%b start=%b ack=%b exp 1/000/0/0/000",
                     in_high, bus.grant, bus.busy, bus.mm_start, bus.ack);
        else n_pass++;
        bus.req = 3'b000;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clock); #1;
            if (bus.ack !== 3'b000 || bus.grant !== 3'b000) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL reset_mid_no_ack got %0d active cycles exp 0", bad);
        else n_pass++;
        @(negedge clock);
        bus.req = 3'b111;
        @(posedge clock); #1;
        n_checks++;
        if (bus.grant !== 3'b001) $display("FAIL reset_first_winner got grant=%b exp 001", bus.grant);
        else n_pass++;
        @(negedge clock);
        bus.req = 3'b000;
    endtask

    task automatic test_timeout();
        do_reset();
        eng_stuck = 1'b1;
        bus.req = 3'b001;
        @(posedge clock); #1;
        n_checks++;
        if (bus.grant !== 3'b001) $display("FAIL timeout_grant got grant=%b exp 001", bus.grant);
        else n_pass++;
`ifdef MAT_ARB_TIMEOUT_EN
        for (int p = 1; p <= int'(TO_CYC) + 2; p++) begin
            logic [2:0] exp_ack;
            logic       exp_err;
            @(posedge clock); #1;
            exp_ack = (p == int'(TO_CYC) + 2) ? 3'b001 : 3'b000;
            exp_err = (p == int'(TO_CYC) + 2);
            n_checks++;
            if (bus.ack !== exp_ack || bus.timeout_err !== exp_err)
                $display("FAIL timeout_path phase=%0d got ack=%b terr=%b exp %b/%b",
                         p, bus.ack, bus.timeout_err, exp_ack, exp_err);
            else n_pass++;
        end
        @(negedge clock);
        bus.req = 3'b000;
        for (int c = 0; c < 4; c++) begin
            @(posedge clock); #1;
            n_checks++;
            if (bus.timeout_err !== 1'b1 || bus.grant !== 3'b000)
                $display("FAIL timeout_sticky cyc=%0d got terr=%b grant=%b exp 1/000", c, bus.timeout_err, bus.grant);
            else n_pass++;
        end
`else
        begin
            int bad;
            bad = 0;
            for (int c = 0; c < 300; c++) begin
                @(posedge clock); #1;
                if (bus.ack !== 3'b000 || bus.busy !== 1'b1 || bus.grant !== 3'b001 || bus.timeout_err !== 1'b0)
                    bad++;
            end
            n_checks++;
            if (bad != 0) $display("FAIL no_timeout_wait got %0d deviating cycles exp 0", bad);
            else n_pass++;
        end
`endif
        resetn = 1'b0;
        #1;
        n_checks++;
        if (bus.timeout_err !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL timeout_reset_clear got terr=%b busy=%b exp 0/0", bus.timeout_err, bus.busy);
        else n_pass++;
        do_reset();
    endtask

    task automatic test_random();
        int         m_owner;
        int         m_phase;
        int         m_last;
        bit         m_seen_low;
        bit         m_exit;
        int         acks[3];
        logic [2:0] last_ack;
        logic [2:0] exp_g;
        logic [2:0] exp_ack;
        int         pick;
        do_reset();
        m_owner = -1;
        m_phase = 0;
        m_last = 2;
        m_seen_low = 1'b0;
        m_exit = 1'b0;
        acks = '{0, 0, 0};
        last_ack = 3'b000;
        for (int c = 0; c < 3000; c++) begin
            logic [2:0] r;
            @(negedge clock);
            r = bus.req;
            for (int i = 0; i < 3; i++) begin
                if (last_ack[i]) r[i] = 1'($urandom_range(0, 1));
                else if (!r[i] && $urandom_range(0, 2) == 0) r[i] = 1'b1;
            end
            bus.req = r;
            eng_run = int'($urandom_range(1, 5));
            @(posedge clock); #1;
            last_ack = bus.ack;
            n_checks++;
            if (!$onehot0(bus.ack) || (bus.ack !== 3'b000 && bus.mm_start))
                $display("FAIL rand_ack_shape cyc=%0d got ack=%b start=%b", c, bus.ack, bus.mm_start);
            else n_pass++;
            if (m_exit) begin
                m_exit = 1'b0;
                m_owner = -1;
                n_checks++;
                if (bus.grant !== 3'b000 || bus.busy !== 1'b0 || bus.ack !== 3'b000)
                    $display("FAIL rand_release cyc=%0d got grant=%b busy=%b ack=%b exp 000/0/000",
                             c, bus.grant, bus.busy, bus.ack);
                else n_pass++;
            end else if (m_owner < 0) begin
                pick = rr_pick(bus.req, m_last);
                exp_g = (pick >= 0) ? 3'(1 << pick) : 3'b000;
                n_checks++;
                if (bus.grant !== exp_g || bus.busy !== (pick >= 0) || bus.mm_start !== 1'b0 ||
                    bus.ack !== 3'b000 || (pick >= 0 && bus.sel !== 2'(pick)))
                    $display("FAIL rand_arbitrate cyc=%0d req=%b got grant=%b sel=%0d busy=%b exp grant=%b",
                             c, bus.req, bus.grant, bus.sel, bus.busy, exp_g);
                else n_pass++;
                if (pick >= 0) begin
                    m_owner = pick;
                    m_phase = 0;
                    m_seen_low = 1'b0;
                end
            end else begin
                m_phase++;
                exp_ack = 3'b000;
                if (m_phase >= 3) begin
                    if (!m_seen_low) begin
                        if (!bus.mm_done) m_seen_low = 1'b1;
                    end else if (bus.mm_done) begin
                        exp_ack = 3'(1 << m_owner);
                    end
                end
                n_checks++;
                if (bus.grant !== 3'(1 << m_owner) || bus.sel !== 2'(m_owner) || bus.busy !== 1'b1 ||
                    bus.mm_start !== (m_phase == 1) || bus.ack !== exp_ack)
                    $display("FAIL rand_txn cyc=%0d phase=%0d got grant=%b sel=%0d start=%b ack=%b exp owner=%0d ack=%b",
                             c, m_phase, bus.grant, bus.sel, bus.mm_start, bus.ack, m_owner, exp_ack);
                else n_pass++;
                if (exp_ack != 3'b000) begin
                    acks[m_owner]++;
                    m_last = m_owner;
                    m_exit = 1'b1;
                end
            end
        end
        n_checks++;
        if (acks[0] < 20 || acks[1] < 20 || acks[2] < 20)
            $display("FAIL rand_fairness got acks=%0d/%0d/%0d exp each >= 20", acks[0], acks[1], acks[2]);
        else n_pass++;
        @(negedge clock);
        bus.req = 3'b000;
    endtask

    initial begin
        n_checks = 0;
        n_pass = 0;
        eng_run = 4;
        eng_stuck = 1'b0;
        resetn = 1'b0;
        bus.req = 3'b000;
        test_reset();
        test_single();
        test_all_req();
        test_drop_req();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
